// File: rtl/keypad_pkg.sv
// keypad_pkg: key bit indices, 7-segment font and one-hot key decoding shared by the keypad entry blocks
package keypad_pkg;
  localparam int KEY_STAR = 9;
  localparam int KEY_ZERO = 10;
  localparam int KEY_HASH = 11;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011
  };
  // Bits 0..8 carry '1'..'9'; KEY_ZERO and the command keys decode to 0.
  function automatic logic [4:0] key_to_bcd(input logic [11:0] k);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) if (k[i]) b = 4'(i + 1);
    return {$onehot(k), b};
  endfunction
endpackage

// File: rtl/keypad_entry_display_if.sv
// keypad_entry_display_if: scanner key input plus display/commit outputs of the keypad entry buffer
interface keypad_entry_display_if #(parameter int N = 4);
  logic [11:0]              scan_data;
  logic                     valid;
  logic [7*N-1:0]           seg;
  logic [4*N-1:0]           value_bcd;
  logic                     en;
  logic [$clog2(N)-1:0]     cursor;
  logic [$clog2(N+1)-1:0]   count;
  logic                     err;
  modport master (output scan_data, valid, input seg, value_bcd, en, cursor, count, err);
  modport slave (input scan_data, valid, output seg, value_bcd, en, cursor, count, err);
endinterface

// File: rtl/keypad_entry_display_seg7_decode.sv
// seg7_decode: BCD digit to active-high {a..g} segments, dark when blanked or out of range
module seg7_decode
  import keypad_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd];
endmodule

// File: rtl/keypad_entry_display.sv
// keypad_entry_display: multi-digit keypad entry buffer (cursor or shift mode) with blink and commit
module keypad_entry_display
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int MODE            = 0,
  parameter int BLINK_DIV       = 25000000,
  parameter int CLEAR_ON_COMMIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  keypad_entry_display_if.slave bus
);
  localparam int N  = NUM_DIGITS;
  localparam int CW = $clog2(N);
  localparam int NW = $clog2(N + 1);

  logic [3:0]     dig [N];
  logic [CW-1:0]  cur, nxt;
  logic [NW-1:0]  cnt;
  logic [4*N-1:0] flat;
  logic [31:0]    bcnt;
  logic [3:0]     bcd;
  logic           valid_d, phase, evt, ok, star, hash, blink;

  assign evt       = bus.valid & ~valid_d;
  assign {ok, bcd} = key_to_bcd(bus.scan_data);
  assign star      = bus.scan_data[KEY_STAR];
  assign hash      = bus.scan_data[KEY_HASH];
  assign nxt       = (cur == CW'(N - 1)) ? '0 : cur + 1'b1;
  assign blink     = (BLINK_DIV != 0) && phase;
  assign bus.cursor = (MODE == 0) ? cur : (cnt == '0) ? '0 : CW'(cnt - 1'b1);
  assign bus.count  = (MODE == 0) ? NW'(N) : cnt;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_dig
      logic blank;
      assign flat[4*i +: 4] = dig[i];
      // Shift mode blanks unused positions and blinks the next entry slot while room remains.
      assign blank = (MODE == 0) ? (blink && cur == CW'(i))
                                 : (NW'(i) >= cnt) || (i == 0 && blink && cnt != NW'(N));
      seg7_decode u_seg (.bcd(dig[i]), .blank(blank), .seg(bus.seg[7*i +: 7]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) dig[k] <= '0;
      cur           <= '0;
      cnt           <= '0;
      bus.value_bcd <= '0;
      bus.en        <= 1'b0;
      bus.err       <= 1'b0;
      valid_d       <= 1'b0;
      bcnt          <= '0;
      phase         <= 1'b0;
    end else begin
      valid_d <= bus.valid;
      bus.en  <= 1'b0;
      bus.err <= 1'b0;
      if (evt) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (BLINK_DIV != 0) begin
        bcnt <= (bcnt == 32'(BLINK_DIV - 1)) ? '0 : bcnt + 1;
        if (bcnt == 32'(BLINK_DIV - 1)) phase <= ~phase;
      end
      if (evt) begin
        if (!ok) bus.err <= 1'b1;
        else if (star) begin
          bus.en        <= 1'b1;
          bus.value_bcd <= flat;
          if (CLEAR_ON_COMMIT != 0) begin
            for (int k = 0; k < N; k++) dig[k] <= '0;
            cur <= '0;
            cnt <= '0;
          end
        end else if (MODE == 0) begin
          if (hash) begin
            cur      <= nxt;
            dig[nxt] <= '0;
          end else dig[cur] <= bcd;
        end else if (hash) begin
          if (cnt != '0) begin
            for (int k = 0; k < N - 1; k++) dig[k] <= dig[k+1];
            dig[N-1] <= '0;
            cnt      <= cnt - 1'b1;
          end
        end else if (cnt == NW'(N)) bus.err <= 1'b1;
        else begin
          for (int k = 1; k < N; k++) dig[k] <= dig[k-1];
          dig[0] <= bcd;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
